ecdsa_share_combiner: RTL and testbench
=======================================

Name: ecdsa_share_combiner

Overview:
Receive end of the threshold-signing path. Collects partial ECDSA signature shares from the partial signers, validates each one, and accumulates s-shares modulo the curve order n. Emits the combined {r, s} signature once THRESHOLD distinct shares have been accepted. Shares arrive already Lagrange-weighted from upstream, so combining is a modular sum only.

Parameters:
MAX_SHARES, 8, number of share slots; share_index must be in 0..MAX_SHARES-1
THRESHOLD, 3, distinct shares required for completion; 1 <= THRESHOLD <= MAX_SHARES
IDX_W, $clog2(MAX_SHARES), width of share_index

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; opens a new session and latches message_hash
message_hash  in  128  hash bound to the session
share_valid  in  1  share offered
share_ready  out  1  combiner accepts share this cycle
share_index  in  IDX_W  signer slot id
share_hash  in  128  hash the share was computed over
share_r  in  256  r component (common to all shares)
share_s  in  256  weighted s-share
signature_out  out  512  {r[255:0], s[255:0]}
done  out  1  combined signature valid, held until start or reset
error  out  1  session aborted, held until start or reset
error_code  out  3  0 none, 1 r mismatch, 2 hash mismatch, 3 zero s
share_reject  out  1  one-cycle pulse: offered share dropped (duplicate, index >= MAX_SHARES, or s >= n)
shares_accepted  out  IDX_W+1  distinct shares accumulated this session

Behaviour:
- Reset values: all outputs 0, state IDLE, accumulator 0, slot bitmap 0. Reset mid-session discards everything.
- FSM states: IDLE, COLLECT, ACCUM, FINAL, DONE, ERROR.
- start in any state → COLLECT. Clears accumulator, bitmap, count, done, error, error_code and signature_out; latches message_hash. start has priority over every other event.
- share_ready = 1 only in COLLECT. A handshake is share_valid & share_ready.
- Handshake on a share with a used index, index >= MAX_SHARES, or share_s >= n:
  - share_reject pulses on the next cycle.
  - No state change.
- First accepted share latches r_ref = share_r.
- Later shares with share_r != r_ref → ERROR, code 1.
- share_hash != latched hash → ERROR, code 2.
- Hash check takes priority over the r check.
- Valid share:
  - Set its bitmap bit, increment shares_accepted, register the operand, go to ACCUM.
  - ACCUM computes acc = (acc + s) mod n using a 257-bit sum and one conditional subtract of n. acc < n is an invariant.
  - ACCUM returns to COLLECT if count < THRESHOLD, else goes to FINAL.
- FINAL:
  - acc == 0 → ERROR, code 3.
  - Otherwise register signature_out = {r_ref, acc}, set done, go to DONE.
- Latency: for the THRESHOLD-th share, the handshake is at edge T; done is visible after edge T+3. Throughput is one share per 2 cycles.
- DONE and ERROR are absorbing until start. Shares offered in IDLE, DONE or ERROR are not accepted (share_ready = 0) and raise no reject.
- Bitmap persists across the session, so a duplicate index is rejected even after the wrap-reduction path was taken.

Optional Feature:
LOW_S_NORMALIZE_EN:
- Defined: FINAL replaces s with n - s when s > (n-1)/2, producing canonical low-s output.
- Undefined: s is output unmodified.
- The zero check precedes normalization in both builds. Latency is unchanged.

Decomposition:
- Package ecdsa_pkg: P-256 order n (FFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632551), HALF_N, error_code localparams, FSM state enum.
- Sub-module mod_n_adder: combinational (a + b) mod n for a, b < n. Reused by the existing signer datapath.

Test Plan:
- THRESHOLD=3; shares idx 0,1,2 with s = 5, 7, 11, matching r/hash → signature_out s = 23, r = r_ref, done 3 cycles after the third handshake, shares_accepted = 3.
- Wrap: s = n-1, 2, 5 → s = 6; each intermediate accumulator < n.
- Duplicate: idx 4 sent twice, then idx 5 and 6 → second idx-4 share gets a share_reject pulse; final s omits the duplicate; done.
- Share 2 with a different r → error = 1, error_code = 1, done = 0. A subsequent start clears both and a new session completes.
- s = 1, n-3, 2 → error_code = 3. Also: share_s = n → share_reject pulse, count unchanged.
- With LOW_S_NORMALIZE_EN: s = 1, 1, n-3 (sum n-1) → s_out = 1. Without it: s_out = n-1. Reset asserted mid-ACCUM → all outputs 0 and share_ready = 0 on the next cycle.

Source files
------------

// File: rtl/ecdsa_pkg.sv
// Shared constants and types for the threshold ECDSA datapath (P-256 group order).
package ecdsa_pkg;

  localparam int unsigned SCALAR_W = 256;
  localparam int unsigned HASH_W   = 128;
  localparam int unsigned CODE_W   = 3;

  localparam logic [SCALAR_W-1:0] N_ORDER =
    256'hFFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632551;
  // n is odd, so (n-1)/2 is a plain shift
  localparam logic [SCALAR_W-1:0] HALF_N = N_ORDER >> 1;

  localparam logic [CODE_W-1:0] ERR_NONE = 3'd0;
  localparam logic [CODE_W-1:0] ERR_R    = 3'd1;
  localparam logic [CODE_W-1:0] ERR_HASH = 3'd2;
  localparam logic [CODE_W-1:0] ERR_ZERO = 3'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    ACCUM   = 3'd2,
    FINAL   = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } state_t;

  typedef struct packed {
    logic [SCALAR_W-1:0] r;
    logic [SCALAR_W-1:0] s;
  } signature_t;

endpackage

// File: rtl/mod_n_adder.sv
// Combinational (a + b) mod n for operands already reduced below n.
module mod_n_adder
  import ecdsa_pkg::*;
(
  input  logic [SCALAR_W-1:0] a,
  input  logic [SCALAR_W-1:0] b,
  output logic [SCALAR_W-1:0] sum_c
);

  logic [SCALAR_W:0] sum;
  logic [SCALAR_W:0] diff;

  // a + b < 2n, so one conditional subtract suffices; a borrow means sum < n
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = sum - {1'b0, N_ORDER};
    sum_c = diff[SCALAR_W] ? sum[SCALAR_W-1:0] : diff[SCALAR_W-1:0];
  end

endmodule

// File: rtl/ecdsa_share_combiner.sv
// Collects Lagrange-weighted ECDSA s-shares and sums them mod n into {r, s}.
// Optional build macro LOW_S_NORMALIZE_EN: emit canonical low-s in FINAL.
module ecdsa_share_combiner
  import ecdsa_pkg::*;
#(
  parameter int unsigned MAX_SHARES = 8,
  parameter int unsigned THRESHOLD  = 3,
  parameter int unsigned IDX_W      = $clog2(MAX_SHARES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [HASH_W-1:0]     message_hash,
  input  logic                  share_valid,
  output logic                  share_ready,
  input  logic [IDX_W-1:0]      share_index,
  input  logic [HASH_W-1:0]     share_hash,
  input  logic [SCALAR_W-1:0]   share_r,
  input  logic [SCALAR_W-1:0]   share_s,
  output logic [2*SCALAR_W-1:0] signature_out,
  output logic                  done,
  output logic                  error,
  output logic [CODE_W-1:0]     error_code,
  output logic                  share_reject,
  output logic [IDX_W:0]        shares_accepted
);

  state_t                state_q, state_d;
  logic [SCALAR_W-1:0]   acc_q, acc_d;
  logic [SCALAR_W-1:0]   operand_q, operand_d;
  logic [SCALAR_W-1:0]   r_ref_q, r_ref_d;
  logic [HASH_W-1:0]     hash_q, hash_d;
  logic [MAX_SHARES-1:0] bitmap_q, bitmap_d;
  logic [IDX_W:0]        count_q, count_d;
  signature_t            sig_q, sig_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [CODE_W-1:0]     code_q, code_d;
  logic                  reject_q, reject_d;
  logic                  ready_q, ready_d;

  logic [SCALAR_W-1:0]   acc_sum_c;
  logic [SCALAR_W-1:0]   s_final_c;
  logic                  idx_ok_c;
  logic                  drop_c;

  mod_n_adder u_add (
    .a     (acc_q),
    .b     (operand_q),
    .sum_c (acc_sum_c)
  );

  always_comb begin
`ifdef LOW_S_NORMALIZE_EN
    s_final_c = (acc_q > HALF_N) ? (N_ORDER - acc_q) : acc_q;
`else
    s_final_c = acc_q;
`endif
  end

  // Drop reasons: out-of-range slot, slot already used, or s not reduced mod n
  always_comb begin
    idx_ok_c = 32'(share_index) < MAX_SHARES;
    drop_c   = !idx_ok_c || bitmap_q[share_index] || (share_s >= N_ORDER);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    operand_d = operand_q;
    r_ref_d   = r_ref_q;
    hash_d    = hash_q;
    bitmap_d  = bitmap_q;
    count_d   = count_q;
    sig_d     = sig_q;
    error_d   = error_q;
    code_d    = code_q;
    reject_d  = 1'b0;

    if (start) begin
      state_d  = COLLECT;
      acc_d    = '0;
      bitmap_d = '0;
      count_d  = '0;
      sig_d    = '0;
      error_d  = 1'b0;
      code_d   = ERR_NONE;
      hash_d   = message_hash;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (share_valid && ready_q) begin
            if (drop_c) begin
              reject_d = 1'b1;
            end else if (share_hash != hash_q) begin
              state_d = ERROR;
              error_d = 1'b1;
              code_d  = ERR_HASH;
            end else if ((count_q != '0) && (share_r != r_ref_q)) begin
              state_d = ERROR;
              error_d = 1'b1;
              code_d  = ERR_R;
            end else begin
              bitmap_d[share_index] = 1'b1;
              count_d   = count_q + (IDX_W+1)'(1);
              operand_d = share_s;
              if (count_q == '0) r_ref_d = share_r;
              state_d   = ACCUM;
            end
          end
        end
        ACCUM: begin
          acc_d   = acc_sum_c;
          state_d = (32'(count_q) < THRESHOLD) ? COLLECT : FINAL;
        end
        FINAL: begin
          if (acc_q == '0) begin
            state_d = ERROR;
            error_d = 1'b1;
            code_d  = ERR_ZERO;
          end else begin
            sig_d.r = r_ref_q;
            sig_d.s = s_final_c;
            state_d = DONE;
          end
        end
        default: ;
      endcase
    end

    // done trails the DONE entry by one cycle, keeping latency at handshake+3
    done_d  = (state_q == DONE) && !start;
    ready_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      operand_q <= '0;
      r_ref_q   <= '0;
      hash_q    <= '0;
      bitmap_q  <= '0;
      count_q   <= '0;
      sig_q     <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      code_q    <= ERR_NONE;
      reject_q  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      operand_q <= operand_d;
      r_ref_q   <= r_ref_d;
      hash_q    <= hash_d;
      bitmap_q  <= bitmap_d;
      count_q   <= count_d;
      sig_q     <= sig_d;
      done_q    <= done_d;
      error_q   <= error_d;
      code_q    <= code_d;
      reject_q  <= reject_d;
      ready_q   <= ready_d;
    end
  end

  assign share_ready     = ready_q;
  assign signature_out   = sig_q;
  assign done            = done_q;
  assign error           = error_q;
  assign error_code      = code_q;
  assign share_reject    = reject_q;
  assign shares_accepted = count_q;

endmodule

// File: tb/tb_ecdsa_share_combiner.sv
// Bench for ecdsa_share_combiner: session-level model plus directed share sequences.
module tb_ecdsa_share_combiner;

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned THRESH = 3;
  localparam int          NEVER  = 32'h7fffffff;
  localparam logic [255:0] N =
    256'hFFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632551;

  localparam logic [255:0] R1 = 256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0001;
  localparam logic [255:0] R2 = 256'h0abc_def0_1234_5678_0abc_def0_1234_5678_0abc_def0_1234_5678_0abc_def0_1234_5678;
  localparam logic [127:0] H1 = 128'hdead_beef_cafe_f00d_0123_4567_89ab_cdef;
  localparam logic [127:0] H2 = 128'h0f0f_0f0f_a5a5_a5a5_5a5a_5a5a_f0f0_f0f0;

  logic clk = 1'b0;
  logic reset, start, share_valid;
  logic [127:0] message_hash, share_hash;
  logic [IDX_W-1:0] share_index;
  logic [255:0] share_r, share_s;
  logic share_ready, done, error, share_reject;
  logic [511:0] signature_out;
  logic [2:0] error_code;
  logic [IDX_W:0] shares_accepted;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  ecdsa_share_combiner dut (
    .clk(clk), .reset(reset), .start(start), .message_hash(message_hash),
    .share_valid(share_valid), .share_ready(share_ready), .share_index(share_index),
    .share_hash(share_hash), .share_r(share_r), .share_s(share_s),
    .signature_out(signature_out), .done(done), .error(error), .error_code(error_code),
    .share_reject(share_reject), .shares_accepted(shares_accepted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- session-level reference model ----------------
  typedef enum int {P_IDLE, P_COLLECT, P_FINISH, P_ERR} phase_t;
  phase_t m_phase = P_IDLE;
  int cyc = 0;
  int m_ready_from = NEVER, m_done_at = NEVER, m_err_at = NEVER, m_reject_at = NEVER;
  int m_count = 0;
  bit [7:0] m_used = '0;
  logic [255:0] m_sum = '0, m_r = '0;
  logic [127:0] m_hash = '0;
  logic [2:0] m_code = '0;
  logic [511:0] m_sig = '0;

  function automatic logic [255:0] canon(input logic [255:0] s);
`ifdef LOW_S_NORMALIZE_EN
    if (s > (N - 256'd1) / 256'd2) return N - s;
`endif
    return s;
  endfunction

  function automatic bit model_ready();
    return (m_phase == P_COLLECT) && (cyc >= m_ready_from);
  endfunction

  always @(posedge clk) begin
    bit rdy;
    rdy = model_ready();
    cyc = cyc + 1;
    if (reset) begin
      m_phase = P_IDLE; m_count = 0; m_used = '0; m_sum = '0; m_code = '0;
      m_ready_from = NEVER; m_done_at = NEVER; m_err_at = NEVER; m_reject_at = NEVER;
    end else if (start) begin
      m_phase = P_COLLECT; m_count = 0; m_used = '0; m_sum = '0; m_code = '0;
      m_hash = message_hash; m_ready_from = cyc;
      m_done_at = NEVER; m_err_at = NEVER;
    end else if (share_valid && rdy) begin
      if (int'(share_index) >= 8 || m_used[share_index] || share_s >= N) begin
        m_reject_at = cyc;
      end else if (share_hash != m_hash) begin
        m_phase = P_ERR; m_err_at = cyc; m_code = 3'd2;
      end else if (m_count > 0 && share_r != m_r) begin
        m_phase = P_ERR; m_err_at = cyc; m_code = 3'd1;
      end else begin
        if (m_count == 0) m_r = share_r;
        m_used[share_index] = 1'b1;
        m_count++;
        m_sum = 256'(({1'b0, m_sum} + {1'b0, share_s}) % {1'b0, N});
        if (m_count >= int'(THRESH)) begin
          if (m_sum == '0) begin
            m_phase = P_ERR; m_err_at = cyc + 2; m_code = 3'd3;
          end else begin
            m_phase = P_FINISH; m_done_at = cyc + 3; m_sig = {m_r, canon(m_sum)};
          end
        end else begin
          m_ready_from = cyc + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("share_ready", 512'(share_ready), 512'(model_ready()));
      chk("share_reject", 512'(share_reject), 512'(cyc == m_reject_at));
      chk("done", 512'(done), 512'(cyc >= m_done_at));
      chk("error", 512'(error), 512'(cyc >= m_err_at));
      chk("error_code", 512'(error_code), 512'((cyc >= m_err_at) ? m_code : 3'd0));
      chk("shares_accepted", 512'(shares_accepted), 512'(m_count));
      if (cyc >= m_done_at) chk("signature", signature_out, m_sig);
      else if (m_phase != P_FINISH) chk("signature_zero", signature_out, 512'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic begin_session(input logic [127:0] h);
    @(negedge clk);
    start = 1'b1; message_hash = h;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int idx, input logic [255:0] s, input logic [255:0] r,
                      input logic [127:0] h);
    bit got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      share_valid = 1'b1; share_index = IDX_W'(idx); share_s = s; share_r = r; share_hash = h;
      got = share_ready;
      @(posedge clk);
    end
    if (!got) chk("handshake_timeout", 512'd0, 512'd1);
    @(negedge clk);
    share_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; share_valid = 1'b0; message_hash = '0;
    share_hash = '0; share_index = '0; share_r = '0; share_s = '0;
    chk_en = 1'b1;
    idle(3);
    chk("rst_done", 512'(done), 512'd0);
    chk("rst_ready", 512'(share_ready), 512'd0);
    chk("rst_sig", signature_out, 512'd0);
    reset = 1'b0;
    idle(2);

    // basic sum 5 + 7 + 11
    begin_session(H1);
    send(0, 256'd5, R1, H1);
    send(1, 256'd7, R1, H1);
    send(2, 256'd11, R1, H1);
    idle(4);
    chk("basic_s", 512'(signature_out[255:0]), 512'd23);
    chk("basic_r", 512'(signature_out[511:256]), 512'(R1));
    chk("basic_count", 512'(shares_accepted), 512'd3);
    chk("basic_done", 512'(done), 512'd1);
    // offers while DONE are ignored without reject
    @(negedge clk);
    share_valid = 1'b1; share_index = 3'd5; share_s = 256'd1; share_r = R1; share_hash = H1;
    idle(3);
    share_valid = 1'b0;

    // wrap-around: (n-1) + 2 + 5 = 6 mod n
    begin_session(H2);
    send(3, N - 256'd1, R2, H2);
    send(0, 256'd2, R2, H2);
    send(7, 256'd5, R2, H2);
    idle(4);
    chk("wrap_s", 512'(signature_out[255:0]), 512'd6);

    // duplicate slot 4 is dropped
    begin_session(H1);
    send(4, 256'd3, R1, H1);
    send(4, 256'd100, R1, H1);
    send(5, 256'd4, R1, H1);
    send(6, 256'd9, R1, H1);
    idle(4);
    chk("dup_s", 512'(signature_out[255:0]), 512'd16);

    // r mismatch on second share, then recover
    begin_session(H1);
    send(0, 256'd1, R1, H1);
    send(1, 256'd2, R2, H1);
    idle(2);
    chk("rmis_error", 512'(error), 512'd1);
    chk("rmis_code", 512'(error_code), 512'd1);
    chk("rmis_done", 512'(done), 512'd0);
    begin_session(H2);
    chk("restart_error", 512'(error), 512'd0);
    send(1, 256'd1, R2, H2);
    send(2, 256'd2, R2, H2);
    send(3, 256'd3, R2, H2);
    idle(4);
    chk("restart_s", 512'(signature_out[255:0]), 512'd6);

    // hash mismatch on first share
    begin_session(H1);
    send(0, 256'd1, R1, H2);
    idle(2);
    chk("hash_code", 512'(error_code), 512'd2);

    // s = n rejected, then sum reaches zero
    begin_session(H1);
    send(0, 256'd1, R1, H1);
    send(1, N, R1, H1);
    idle(1);
    chk("sn_count", 512'(shares_accepted), 512'd1);
    send(2, N - 256'd3, R1, H1);
    send(3, 256'd2, R1, H1);
    idle(4);
    chk("zero_code", 512'(error_code), 512'd3);

    // sum n-1: low-s build folds to 1
    begin_session(H2);
    send(0, 256'd1, R1, H2);
    send(1, 256'd1, R1, H2);
    send(2, N - 256'd3, R1, H2);
    idle(4);
`ifdef LOW_S_NORMALIZE_EN
    chk("lows_s", 512'(signature_out[255:0]), 512'd1);
`else
    chk("lows_s", 512'(signature_out[255:0]), 512'(N - 256'd1));
`endif

    // reset while ACCUM
    begin_session(H1);
    send(0, 256'd9, R1, H1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 512'(share_ready), 512'd0);
    chk("midrst_count", 512'(shares_accepted), 512'd0);
    chk("midrst_sig", signature_out, 512'd0);
    reset = 1'b0;
    idle(3);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
